// File: rtl/rad_sweep_gen.sv
// Radian sweep generator feeding the CORDIC input FIFO: start_angle + k*step for count samples.
// Optional range folding into [-PI, PI] is enabled by defining RAD_SWEEP_WRAP_EN.
module rad_sweep_gen #(
   parameter int COUNT_W       = 16,
   parameter int CORDIC_PI     = 51471,
   parameter int CORDIC_TWO_PI = 102943
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [31:0]        start_angle,
   input  logic [31:0]        step,
   input  logic [COUNT_W-1:0] count,
   output logic               busy,
   output logic               done,
   output logic               out_wr_en,
   input  logic               out_full,
   output logic [31:0]        out_din
);

`ifdef RAD_SWEEP_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   localparam logic signed [32:0] PI_33     = 33'(CORDIC_PI);
   localparam logic signed [32:0] NEG_PI_33 = -33'(CORDIC_PI);
   localparam logic signed [32:0] TWO_PI_33 = 33'(CORDIC_TWO_PI);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        angle_q, angle_d;
   logic [31:0]        step_q, step_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;

   logic signed [32:0] sum_s;
   logic [31:0]        next_angle_s;
   logic               wr_s;

   assign sum_s = $signed({angle_q[31], angle_q}) + $signed({step_q[31], step_q});

   // Next sample: plain two's-complement wrap, or a single +/-2*PI fold when enabled
   always_comb begin
      next_angle_s = sum_s[31:0];
      if (!WRAP_EN) begin
         next_angle_s = sum_s[31:0];
      end else if (sum_s > PI_33) begin
         next_angle_s = 32'(sum_s - TWO_PI_33);
      end else if (sum_s < NEG_PI_33) begin
         next_angle_s = 32'(sum_s + TWO_PI_33);
      end else begin
         next_angle_s = sum_s[31:0];
      end
   end

   // State and operand registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         angle_q     <= 32'd0;
         step_q      <= 32'd0;
         remaining_q <= {COUNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         angle_q     <= angle_d;
         step_q      <= step_d;
         remaining_q <= remaining_d;
      end
   end

   // Next-state logic; a write happens in RUN on every cycle the FIFO is not full
   always_comb begin
      state_d     = state_q;
      angle_d     = angle_q;
      step_d      = step_q;
      remaining_d = remaining_q;
      wr_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (count != {COUNT_W{1'b0}}) begin
                  angle_d     = start_angle;
                  step_d      = step;
                  remaining_d = count;
                  state_d     = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!out_full) begin
               wr_s        = 1'b1;
               angle_d     = next_angle_s;
               remaining_d = remaining_q - {{(COUNT_W-1){1'b0}}, 1'b1};
               if (remaining_q == {{(COUNT_W-1){1'b0}}, 1'b1}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode straight from the state register so reset clears them at once
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign out_wr_en = wr_s;
   assign out_din   = (state_q == ST_RUN) ? angle_q : 32'd0;

endmodule

// File: tb/tb_rad_sweep_gen.sv
// Directed self-checking bench for rad_sweep_gen: sweep, backpressure, wrap, zero count,
// start-while-busy and asynchronous reset during a sweep.
module tb_rad_sweep_gen;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [31:0] start_angle;
   logic [31:0] step;
   logic [15:0] count;
   logic        busy;
   logic        done;
   logic        out_wr_en;
   logic        out_full;
   logic [31:0] out_din;

   int checks;
   int errors;

   logic [31:0] wr_q[$];
   int          wr_cyc[$];
   logic [31:0] stall_din[$];
   int          done_cnt;
   int          done_cyc;
   int          busy_cnt;
   bit          finished;

   rad_sweep_gen #(.COUNT_W(16)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .start_angle (start_angle),
      .step        (step),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .out_wr_en   (out_wr_en),
      .out_full    (out_full),
      .out_din     (out_din)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic do_start(input logic [31:0] a, input logic [31:0] s, input logic [15:0] n);
      start_angle = a;
      step        = s;
      count       = n;
      start       = 1'b1;
      @(posedge clock);
      #1;
      start       = 1'b0;
   endtask

   // Records writes/done/busy per cycle (cycle 1 = first cycle after the start edge).
   task automatic capture(input int max_cyc, input logic [31:0] full_mask, input int inj_cyc);
      wr_q.delete();
      wr_cyc.delete();
      stall_din.delete();
      done_cnt = 0;
      done_cyc = 0;
      busy_cnt = 0;
      finished = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         out_full = full_mask[c];
         if (c == inj_cyc) begin
            start       = 1'b1;
            start_angle = 32'h0000_7777;
            step        = 32'd5;
            count       = 16'd3;
         end else begin
            start = 1'b0;
         end
         #1;
         if (out_wr_en) begin
            wr_q.push_back(out_din);
            wr_cyc.push_back(c);
         end
         if (full_mask[c]) stall_din.push_back(out_din);
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (busy) busy_cnt++;
         if (done_cnt > 0 && !busy) begin
            finished = 1'b1;
            break;
         end
         @(posedge clock);
         #1;
      end
      out_full = 1'b0;
      start    = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #2;
      checks++;
      if ({busy, done, out_wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000", {busy, done, out_wr_en});
      end
      checks++;
      if (out_din !== 32'd0) begin
         errors++;
         $display("FAIL reset_din got %0h exp 0", out_din);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy got %b exp 0", busy);
      end
   endtask

   task automatic test_basic;
      logic [31:0] exp_v[4];
      exp_v = '{32'd0, 32'd1608, 32'd3216, 32'd4824};
      do_start(32'd0, 32'd1608, 16'd4);
      capture(20, 32'd0, 0);
      checks++;
      if (wr_q.size() != 4) begin
         errors++;
         $display("FAIL basic_nwr got %0d exp 4", wr_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_q[k] !== exp_v[k] || wr_cyc[k] != k + 1) begin
               errors++;
               $display("FAIL basic_wr%0d got %0d@c%0d exp %0d@c%0d", k, $signed(wr_q[k]), wr_cyc[k], $signed(exp_v[k]), k + 1);
            end
         end
      end
      checks++;
      if (!finished || done_cnt != 1 || done_cyc != 5) begin
         errors++;
         $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=5", done_cnt, done_cyc);
      end
      checks++;
      if (busy_cnt != 5) begin
         errors++;
         $display("FAIL basic_busy got %0d exp 5", busy_cnt);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_v[4];
      int          exp_c[4];
      exp_v = '{32'd0, 32'd1608, 32'd3216, 32'd4824};
      exp_c = '{1, 5, 6, 7};
      do_start(32'd0, 32'd1608, 16'd4);
      capture(20, 32'h0000_001C, 0);
      checks++;
      if (wr_q.size() != 4) begin
         errors++;
         $display("FAIL bp_nwr got %0d exp 4", wr_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_q[k] !== exp_v[k] || wr_cyc[k] != exp_c[k]) begin
               errors++;
               $display("FAIL bp_wr%0d got %0d@c%0d exp %0d@c%0d", k, $signed(wr_q[k]), wr_cyc[k], $signed(exp_v[k]), exp_c[k]);
            end
         end
      end
      checks++;
      if (stall_din.size() != 3) begin
         errors++;
         $display("FAIL bp_nstall got %0d exp 3", stall_din.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (stall_din[k] !== 32'd1608) begin
               errors++;
               $display("FAIL bp_hold%0d got %0d exp 1608", k, $signed(stall_din[k]));
            end
         end
      end
      checks++;
      if (!finished || done_cnt != 1 || done_cyc != 8) begin
         errors++;
         $display("FAIL bp_done got cnt=%0d cyc=%0d exp cnt=1 cyc=8", done_cnt, done_cyc);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] exp_v[3];
`ifdef RAD_SWEEP_WRAP_EN
      exp_v = '{32'd51000, -32'sd50943, -32'sd49943};
`else
      exp_v = '{32'd51000, 32'd52000, 32'd53000};
`endif
      do_start(32'd51000, 32'd1000, 16'd3);
      capture(20, 32'd0, 0);
      checks++;
      if (wr_q.size() != 3) begin
         errors++;
         $display("FAIL wrap_nwr got %0d exp 3", wr_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_q[k] !== exp_v[k]) begin
               errors++;
               $display("FAIL wrap_wr%0d got %0d exp %0d", k, $signed(wr_q[k]), $signed(exp_v[k]));
            end
         end
      end
   endtask

   task automatic test_zero_count;
      do_start(32'd123, 32'd1, 16'd0);
      capture(10, 32'd0, 0);
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL zero_nwr got %0d exp 0", wr_q.size());
      end
      checks++;
      if (!finished || done_cnt != 1 || done_cyc != 1 || busy_cnt != 1) begin
         errors++;
         $display("FAIL zero_done got cnt=%0d cyc=%0d busy=%0d exp 1 1 1", done_cnt, done_cyc, busy_cnt);
      end
   endtask

   task automatic test_start_while_busy;
      logic [31:0] e;
      do_start(32'd100, -32'sd3, 16'd8);
      capture(30, 32'd0, 3);
      checks++;
      if (wr_q.size() != 8) begin
         errors++;
         $display("FAIL busy_nwr got %0d exp 8", wr_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            e = 32'd100 - 32'(3 * k);
            checks++;
            if (wr_q[k] !== e) begin
               errors++;
               $display("FAIL busy_wr%0d got %0d exp %0d", k, $signed(wr_q[k]), $signed(e));
            end
         end
      end
      checks++;
      if (!finished || done_cnt != 1 || done_cyc != 9) begin
         errors++;
         $display("FAIL busy_done got cnt=%0d cyc=%0d exp cnt=1 cyc=9", done_cnt, done_cyc);
      end
   endtask

   task automatic test_reset_mid_run;
      int late_done;
      int late_wr;
      do_start(32'd0, 32'd10, 16'd6);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      checks++;
      if (out_din !== 32'd20) begin
         errors++;
         $display("FAIL rst_pre_din got %0d exp 20", $signed(out_din));
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, out_wr_en} !== 3'b000 || out_din !== 32'd0) begin
         errors++;
         $display("FAIL rst_async got flags=%b din=%0h exp 000 0", {busy, done, out_wr_en}, out_din);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n   = 1'b1;
      late_done = 0;
      late_wr   = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock);
         #1;
         if (done) late_done++;
         if (out_wr_en) late_wr++;
      end
      checks++;
      if (late_done != 0 || late_wr != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_after got done=%0d wr=%0d busy=%b exp 0 0 0", late_done, late_wr, busy);
      end
      do_start(-32'sd500, 32'd7, 16'd2);
      capture(10, 32'd0, 0);
      checks++;
      if (wr_q.size() != 2) begin
         errors++;
         $display("FAIL rst_new_nwr got %0d exp 2", wr_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== -32'sd500 || wr_q[1] !== -32'sd493) begin
            errors++;
            $display("FAIL rst_new_wr got %0d,%0d exp -500,-493", $signed(wr_q[0]), $signed(wr_q[1]));
         end
      end
      checks++;
      if (!finished || done_cnt != 1 || done_cyc != 3) begin
         errors++;
         $display("FAIL rst_new_done got cnt=%0d cyc=%0d exp cnt=1 cyc=3", done_cnt, done_cyc);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      start       = 1'b0;
      start_angle = 32'd0;
      step        = 32'd0;
      count       = 16'd0;
      out_full    = 1'b0;
      reset_n     = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
